// File: rtl/regfile_writeback_if.sv
// Bundle of signals between the issuing pipeline / load unit and the
// register-file writeback arbiter.
interface regfile_writeback_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             alu_valid;
    logic [4:0]       alu_rd;
    logic [31:0]      alu_data;
    logic             mem_valid;
    logic [4:0]       mem_rd;
    logic [31:0]      mem_data;
    logic             mem_ready;
    logic [4:0]       q_rs1;
    logic [4:0]       q_rs2;
    logic             q_hit1;
    logic             q_hit2;
    logic [4:0]       A3;
    logic [31:0]      WD3;
    logic             WE3;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output q_rs1, q_rs2,
        input  mem_ready, q_hit1, q_hit2,
        input  A3, WD3, WE3, fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  q_rs1, q_rs2,
        output mem_ready, q_hit1, q_hit2,
        output A3, WD3, WE3, fifo_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// Single write-port arbiter: ALU results win, load results wait in a small
// FIFO and drain whenever the ALU leaves the port idle.
module regfile_writeback #(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               srst,
    regfile_writeback_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [4:0]       a3_q, a3_d;
    logic [31:0]      wd3_q, wd3_d;
    logic             we3_q, we3_d;

    // Every rd tag is compared each cycle for hazards and the head feeds the
    // write port directly, so the storage is read asynchronously.
    logic [4:0]       rd_mem   [DEPTH];
    logic [31:0]      data_mem [DEPTH];

    logic             mem_ready;
    logic             alu_wr;
    logic             push;
    logic             pop;
    logic [DEPTH-1:0] entry_valid;
    logic [DEPTH-1:0] hit1_vec;
    logic [DEPTH-1:0] hit2_vec;

    assign mem_ready = (count_q < DEPTH_C) && !srst;
    assign alu_wr    = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign push      = bus.mem_valid && mem_ready && (bus.mem_rd != 5'd0);
    assign pop       = !alu_wr && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        we3_d    = 1'b0;
        if (srst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            a3_d     = '0;
            wd3_d    = '0;
        end else begin
            if (alu_wr) begin
                we3_d = 1'b1;
                a3_d  = bus.alu_rd;
                wd3_d = bus.alu_data;
            end else if (pop) begin
                we3_d = 1'b1;
                a3_d  = rd_mem[rd_ptr_q];
                wd3_d = data_mem[rd_ptr_q];
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        a3_q     <= a3_d;
        wd3_q    <= wd3_d;
        we3_q    <= we3_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_q]   <= bus.mem_rd;
            data_mem[wr_ptr_q] <= bus.mem_data;
        end
    end

    // A slot is live when its distance from the head is below the count.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] offset;
            assign offset          = PTR_W'(gi) - rd_ptr_q;
            assign entry_valid[gi] = ({1'b0, offset} < count_q);
            assign hit1_vec[gi]    = entry_valid[gi] && (rd_mem[gi] == bus.q_rs1);
            assign hit2_vec[gi]    = entry_valid[gi] && (rd_mem[gi] == bus.q_rs2);
        end
    endgenerate

    assign bus.q_hit1 = (bus.q_rs1 != 5'd0) &&
                        ((|hit1_vec) || (we3_q && (a3_q == bus.q_rs1)));
    assign bus.q_hit2 = (bus.q_rs2 != 5'd0) &&
                        ((|hit2_vec) || (we3_q && (a3_q == bus.q_rs2)));

    assign bus.mem_ready  = mem_ready;
    assign bus.A3         = a3_q;
    assign bus.WD3        = wd3_q;
    assign bus.WE3        = we3_q;
    assign bus.fifo_count = count_q;
endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter DEPTH, default 4, load-result queue depth; SHALL be a power of two, 2..16.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 srst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 alu_valid  input  1  single-cycle ALU result present this cycle; no backpressure.
REQ-005 alu_rd  input  5  ALU destination register.
REQ-006 alu_data  input  32  ALU result.
REQ-007 mem_valid  input  1  load result offered.
REQ-008 mem_rd  input  5  load destination register.
REQ-009 mem_data  input  32  load data.
REQ-010 mem_ready  output  1  queue can accept a load result this cycle.
REQ-011 q_rs1, q_rs2  input  5 each  source registers queried for pending writes.
REQ-012 q_hit1, q_hit2  output  1 each  a pending write targets q_rs1 / q_rs2.
REQ-013 A3  output  5  register-file write address.
REQ-014 WD3  output  32  register-file write data.
REQ-015 WE3  output  1  register-file write enable.
REQ-016 fifo_count  output  $clog2(DEPTH)+1  queued load entries.

Function
REQ-017 Load handshake SHALL complete on a rising edge with mem_valid && mem_ready both high; mem_valid/mem_rd/mem_data SHALL be sampled only then.
REQ-018 mem_ready SHALL equal (fifo_count < DEPTH) && !srst, derived from registered state only.
REQ-019 An accepted load with mem_rd != 0 SHALL be pushed to the queue tail; mem_rd == 0 SHALL complete the handshake without a push.
REQ-020 A3/WD3/WE3 SHALL be registered and SHALL update every cycle from one source selected by this fixed priority:
- alu_valid && alu_rd != 0 -> {alu_rd, alu_data}, WE3=1;
- else queue non-empty -> pop head, {head.rd, head.data}, WE3=1;
- else WE3=0; A3/WD3 hold their previous values.
REQ-021 alu_valid with alu_rd == 0 SHALL be discarded with no write and SHALL NOT block a queue pop that cycle.
REQ-022 ALU latency SHALL be 1 cycle (input at edge N, WE3 high after edge N).
REQ-023 Minimum load latency SHALL be 2 cycles: push at edge N, pop at edge N+1, WE3 high after edge N+1.
REQ-024 While alu_valid with non-zero rd is present, the queue SHALL NOT pop.
REQ-025 The queue SHALL pop in FIFO order; pointers SHALL wrap modulo DEPTH.
REQ-026 A push and a pop in the same cycle SHALL leave fifo_count unchanged and SHALL be legal at any count, including count 1 (no bypass).
REQ-027 When full, mem_ready SHALL be 0; a pop at that edge SHALL raise mem_ready in the next cycle, not the same cycle.
REQ-028 q_hitN SHALL be combinational and high iff q_rsN != 0 and either:
- a valid queue entry has rd == q_rsN; or
- WE3 && A3 == q_rsN.
REQ-029 Ordering between ALU writes and queued loads to the same register is not preserved; the issuing pipeline SHALL stall on q_hitN to avoid it.
REQ-030 No output SHALL depend combinationally on alu_* or mem_* inputs.

Reset
REQ-031 srst SHALL clear both pointers, fifo_count=0, WE3=0, A3=0, WD3=0 at the next rising edge.
REQ-032 srst SHALL take priority over all other activity: a mid-operation reset SHALL discard queued entries and any same-edge handshake; no write SHALL issue on the reset edge.
REQ-033 After srst deasserts, mem_ready SHALL be 1 in the first cycle and q_hit1/q_hit2 SHALL be 0.
REQ-034 Queue storage contents need no reset.

Verification
REQ-035 ALU path: alu_valid=1, rd=5, data=0x0000_1234 at edge N -> after N: WE3=1, A3=5, WD3=0x1234; after N+1 with no input: WE3=0.
REQ-036 Load path and x0: mem rd=9, data=0x2004 accepted at edge N -> WE3=1, A3=9 after N+1; mem rd=0 accepted -> no write, fifo_count stays 0.
REQ-037 Priority: queue holds rd=3 and alu_valid with rd=7 for 3 cycles -> three writes to x7, then x3 written next cycle; fifo_count goes 1->0 only on that pop.
REQ-038 Full: DEPTH=4, alu_valid held high, 5 load offers -> 4 accepted, mem_ready=0, fifo_count=4; drop alu_valid -> pop, mem_ready=1 next cycle, 5th load then accepted.
REQ-039 Hazard: queue holds rd=12, q_rs1=12, q_rs2=0 -> q_hit1=1, q_hit2=0; after its write completes (WE3 low again), q_hit1=0.
REQ-040 Reset mid-run: fifo_count=3 and srst pulsed one cycle -> fifo_count=0, WE3=0, A3=0, WD3=0, none of the three entries is ever written.
